// File: rtl/cache_stream_reader_pkg.sv
// Shared types and constants for the cache stream reader.
package cache_stream_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DATA,
        HOLD,
        FINISH
    } state_t;

    localparam logic [31:0] ADDR_INC = 32'd4;

endpackage

// File: rtl/cache_stream_reader.sv
// Streams a run of 32-bit words read from the cache out over a valid/ready port.
// Optional pattern check with mismatch counter: define CACHE_STREAM_READER_CHECK_EN.
//
// state     | meaning
// IDLE      | waiting for start; zero-length start only pulses done
// ISSUE     | c_address holds the word address being fetched
// WAIT_DATA | address held until the cache returns data while not busy
// HOLD      | word presented on out_data/out_valid until out_ready
// FINISH    | done pulse, active already low, back to IDLE
module cache_stream_reader
    import cache_stream_reader_pkg::*;
#(
    parameter int          COUNT_BITWIDTH = 16,
    parameter logic [31:0] CHECK_PATTERN  = 32'h01234567
) (
    input  logic                      clk,
    input  logic                      sys_rst_n,
    input  logic                      start,
    input  logic [31:0]               start_address,
    input  logic [COUNT_BITWIDTH-1:0] word_count,
    output logic                      active,
    output logic                      done,
    output logic [31:0]               out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               c_address,
    output logic [3:0]                c_write_enable,
    output logic [31:0]               c_data_in,
    input  logic [31:0]               c_data_out,
    input  logic                      c_data_out_ready,
    input  logic                      c_busy
`ifdef CACHE_STREAM_READER_CHECK_EN
    ,
    output logic [COUNT_BITWIDTH-1:0] mismatch_count
`endif
);

    state_t                    state;
    logic [COUNT_BITWIDTH-1:0] remaining;

    assign c_write_enable = 4'b0000;
    assign c_data_in      = 32'd0;

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            active    <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            c_address <= 32'd0;
            remaining <= '0;
`ifdef CACHE_STREAM_READER_CHECK_EN
            mismatch_count <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            c_address <= start_address;
                            remaining <= word_count;
                            active    <= 1'b1;
                            state     <= ISSUE;
`ifdef CACHE_STREAM_READER_CHECK_EN
                            mismatch_count <= '0;
`endif
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ISSUE: state <= WAIT_DATA;
                WAIT_DATA: begin
                    if (!c_busy && c_data_out_ready) begin
                        out_data  <= c_data_out;
                        out_valid <= 1'b1;
                        state     <= HOLD;
`ifdef CACHE_STREAM_READER_CHECK_EN
                        if (c_data_out != CHECK_PATTERN && mismatch_count != '1)
                            mismatch_count <= mismatch_count + 1'b1;
`endif
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        c_address <= c_address + ADDR_INC;
                        remaining <= remaining - 1'b1;
                        // done is raised here so it is visible during FINISH
                        if (remaining == COUNT_BITWIDTH'(1)) begin
                            done   <= 1'b1;
                            active <= 1'b0;
                            state  <= FINISH;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_stream_reader.sv
// Directed bench for cache_stream_reader with a behavioural cache and a word scoreboard.
module tb_cache_stream_reader;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          sys_rst_n;
    logic          start;
    logic [31:0]   start_address;
    logic [CW-1:0] word_count;
    logic          active;
    logic          done;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   c_address;
    logic [3:0]    c_write_enable;
    logic [31:0]   c_data_in;
    logic [31:0]   c_data_out;
    logic          c_data_out_ready;
    logic          c_busy;
`ifdef CACHE_STREAM_READER_CHECK_EN
    logic [CW-1:0] mismatch_count;
`endif

    cache_stream_reader #(.COUNT_BITWIDTH(CW), .CHECK_PATTERN(32'h01234567)) dut (
        .clk              (clk),
        .sys_rst_n        (sys_rst_n),
        .start            (start),
        .start_address    (start_address),
        .word_count       (word_count),
        .active           (active),
        .done             (done),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .c_address        (c_address),
        .c_write_enable   (c_write_enable),
        .c_data_in        (c_data_in),
        .c_data_out       (c_data_out),
        .c_data_out_ready (c_data_out_ready),
        .c_busy           (c_busy)
`ifdef CACHE_STREAM_READER_CHECK_EN
        ,
        .mismatch_count   (mismatch_count)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem [64];
    logic [31:0] sb [$];

    // cache model: new address -> miss_lat busy cycles, data only valid once address settled
    int          miss_lat  = 0;
    logic        hold_busy = 1'b0;
    int          wait_cnt  = 0;
    logic [31:0] last_addr = 32'd0;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (a[31:8] == 24'h0) return mem[a[7:2]];
        return ~a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic changed;
        changed = (c_address !== last_addr);
        if (changed) begin
            last_addr = c_address;
            wait_cnt  = miss_lat;
        end else if (wait_cnt > 0) begin
            wait_cnt--;
        end
        c_busy           = (wait_cnt != 0) || hold_busy;
        c_data_out_ready = !c_busy && !changed;
        c_data_out       = c_data_out_ready ? model_rd(c_address) : 32'h0BAD0BAD;
    end

    always @(negedge clk) begin
        if (sys_rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL sb_underflow observed=%h expected=none", out_data);
            end
            if (sb.size() != 0) chk("stream_data", out_data, sb.pop_front());
            chk("c_write_enable", {28'd0, c_write_enable}, 32'd0);
            chk("c_data_in", c_data_in, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] a, input logic [CW-1:0] wc);
        start         = 1'b1;
        start_address = a;
        word_count    = wc;
        for (int i = 0; i < int'(wc); i++) sb.push_back(model_rd(a + 32'(4 * i)));
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int cyc = 0;
        while (out_valid !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
        chk(tag, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        int          cyc;
        logic [31:0] held_data;
        logic [31:0] held_addr;

        for (int i = 0; i < 64; i++) mem[i] = 32'h01234567;
        sys_rst_n     = 1'b0;
        start         = 1'b0;
        start_address = 32'd0;
        word_count    = '0;
        out_ready     = 1'b1;
        tick();
        tick();
        chk("rst_active", {31'd0, active}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_c_address", c_address, 32'd0);
`ifdef CACHE_STREAM_READER_CHECK_EN
        chk("rst_mismatch", 32'(mismatch_count), 32'd0);
`endif
        sys_rst_n = 1'b1;
        tick();

        // 64-word run on hits, ready held high
        pulse_start(32'd0, CW'(64));
        chk("run64_active", {31'd0, active}, 32'd1);
        wait_done("run64_done", 400, cyc);
        chk("run64_throughput", 32'(cyc <= 3 * 64), 32'd1);
        chk("run64_active_off", {31'd0, active}, 32'd0);
`ifdef CACHE_STREAM_READER_CHECK_EN
        chk("run64_mismatch", 32'(mismatch_count), 32'd0);
`endif
        tick();
        chk("run64_done_width", {31'd0, done}, 32'd0);
        chk("run64_sb_drain", 32'(sb.size()), 32'd0);
        tick();

        // zero-length run
        held_addr = c_address;
        pulse_start(32'h0000_0080, CW'(0));
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_active", {31'd0, active}, 32'd0);
        tick();
        chk("zero_done_width", {31'd0, done}, 32'd0);
        chk("zero_c_address", c_address, held_addr);
        tick();

        // backpressure in HOLD, with an ignored start mid-run
        miss_lat  = 2;
        out_ready = 1'b0;
        pulse_start(32'h0000_0040, CW'(2));
        wait_valid("bp_valid", 20);
        held_data = out_data;
        held_addr = c_address;
        chk("bp_first_data", held_data, model_rd(32'h0000_0040));
        for (int i = 0; i < 10; i++) begin
            start         = (i == 4);
            start_address = 32'h0000_0080;
            word_count    = CW'(5);
            tick();
            chk("bp_data_stable", out_data, held_data);
            chk("bp_valid_stable", {31'd0, out_valid}, 32'd1);
            chk("bp_addr_stable", c_address, held_addr);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        wait_done("bp_done", 40, cyc);
        tick();
        chk("bp_sb_drain", 32'(sb.size()), 32'd0);
        miss_lat = 0;

        // address wrap
        out_ready = 1'b0;
        pulse_start(32'hFFFF_FFFC, CW'(2));
        chk("wrap_first_addr", c_address, 32'hFFFF_FFFC);
        wait_valid("wrap_valid", 20);
        out_ready = 1'b1;
        tick();
        chk("wrap_second_addr", c_address, 32'd0);
        wait_done("wrap_done", 20, cyc);
        tick();
        chk("wrap_sb_drain", 32'(sb.size()), 32'd0);

        // one corrupt word at address 8
        mem[2] = 32'hDEADBEEF;
        pulse_start(32'd0, CW'(4));
        wait_done("bad_done", 40, cyc);
`ifdef CACHE_STREAM_READER_CHECK_EN
        chk("bad_mismatch", 32'(mismatch_count), 32'd1);
`endif
        tick();
        chk("bad_sb_drain", 32'(sb.size()), 32'd0);
        mem[2] = 32'h01234567;

        // reset while waiting on the cache
        hold_busy = 1'b1;
        pulse_start(32'h0000_0010, CW'(3));
        tick();
        tick();
        chk("rstmid_active_before", {31'd0, active}, 32'd1);
        sys_rst_n = 1'b0;
        tick();
        chk("rstmid_active", {31'd0, active}, 32'd0);
        chk("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstmid_done", {31'd0, done}, 32'd0);
        sys_rst_n = 1'b1;
        hold_busy = 1'b0;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstmid_no_done", {31'd0, done}, 32'd0);
            chk("rstmid_no_valid", {31'd0, out_valid}, 32'd0);
        end
        pulse_start(32'h0000_0020, CW'(3));
        wait_done("rerun_done", 40, cyc);
        tick();
        chk("rerun_sb_drain", 32'(sb.size()), 32'd0);
        chk("rerun_active", {31'd0, active}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
